// File: rtl/tmds_chan_decode.sv
// tmds_chan_decode: single-channel TMDS receive decoder.
// Finds the 10-bit word boundary by pulsing the deserializer bitslip until a
// run of control tokens is seen, then decodes each word into 8-bit pixel data
// or a 2-bit control code. Lives entirely in the recovered pixel-clock domain.
module tmds_chan_decode #(
   parameter int SEARCH_WIN  = 4096,  // search window per phase, and loss timeout
   parameter int CTRL_RUN    = 64,    // consecutive tokens needed to lock
   parameter int SLIP_SETTLE = 3      // idle cycles after each bitslip pulse
) (
   input  logic       pclk,
   input  logic       rstin,
   input  logic [9:0] sdata,
   output logic       bitslip,
   output logic       aligned,
   output logic       psalgnerr,
   output logic [7:0] dout,
   output logic       c0,
   output logic       c1,
   output logic       vde
);

   localparam int WIN_W = $clog2(SEARCH_WIN + 1);
   localparam int RUN_W = $clog2(CTRL_RUN + 1);
   localparam int SET_W = $clog2(SLIP_SETTLE + 1);

   localparam logic [WIN_W-1:0] WIN_MAX  = WIN_W'(SEARCH_WIN);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(CTRL_RUN);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);
   localparam logic [3:0]       SLIP_LAST = 4'd9;

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_SLIP,
      ST_SETTLE,
      ST_LOCKED
   } state_t;

   // ---------------------------------------------------------------------
   // Stage 1: capture the raw word and classify it as a control token.
   // ---------------------------------------------------------------------
   logic       tok_det;
   logic [1:0] code_det;

   logic [9:0] w1_q;
   logic       tok1_q;
   logic [1:0] code1_q;

   // Token match against the four control symbols; code is {c1,c0}.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      tok_det  = 1'b0;
      code_det = 2'b00;
      case (sdata)
         10'b1101010100: begin tok_det = 1'b1; code_det = 2'b00; end
         10'b0010101011: begin tok_det = 1'b1; code_det = 2'b01; end
         10'b0101010100: begin tok_det = 1'b1; code_det = 2'b10; end
         10'b1010101011: begin tok_det = 1'b1; code_det = 2'b11; end
         default:        begin tok_det = 1'b0; code_det = 2'b00; end
      endcase
   end

   // Stage 1 register: word plus its token classification.
   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge pclk) begin
      if (rstin) begin
         w1_q    <= '0;
         tok1_q  <= 1'b0;
         code1_q <= 2'b00;
      end else begin
         w1_q    <= sdata;
         tok1_q  <= tok_det;
         code1_q <= code_det;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: TMDS data decode and output gating.
   // ---------------------------------------------------------------------
   logic [7:0] d_inv;
   logic [7:0] dec;

   // Undo the optional inversion (bit 9) and the XOR/XNOR chain (bit 8).
   always_comb begin
      d_inv  = w1_q[9] ? ~w1_q[7:0] : w1_q[7:0];
      dec    = '0;
      dec[0] = d_inv[0];
      for (int i = 1; i < 8; i++) begin
         dec[i] = w1_q[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
      end
   end

   logic [7:0] dout_q;
   logic       vde_q;
   logic       c0_q;
   logic       c1_q;

   // Output register: silent until aligned, control codes held across video.
   // NOTE: the small datapath registers are reset too, so every output reads 0 out of reset.
   always_ff @(posedge pclk) begin
      if (rstin) begin
         dout_q <= '0;
         vde_q  <= 1'b0;
         c0_q   <= 1'b0;
         c1_q   <= 1'b0;
      end else if (!aligned) begin
         dout_q <= '0;
         vde_q  <= 1'b0;
         c0_q   <= 1'b0;
         c1_q   <= 1'b0;
      end else if (tok1_q) begin
         dout_q <= '0;
         vde_q  <= 1'b0;
         c0_q   <= code1_q[0];
         c1_q   <= code1_q[1];
      end else begin
         dout_q <= dec;
         vde_q  <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Alignment FSM.
   // ---------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [WIN_W-1:0]  win_q, win_d;     // search window in SEARCH, loss timer in LOCKED
   logic [RUN_W-1:0]  run_q, run_d;
   logic [3:0]        slip_q, slip_d;
   logic [SET_W-1:0]  settle_q, settle_d;
   logic              perr_q, perr_d;

   logic [WIN_W-1:0]  win_inc;
   logic [RUN_W-1:0]  run_inc;

   // Next-state logic; the slip counter and psalgnerr update on the edge that
   // enters SLIP so they change together with the bitslip pulse.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      run_d    = run_q;
      slip_d   = slip_q;
      settle_d = settle_q;
      perr_d   = perr_q;

      win_inc  = (win_q == WIN_MAX) ? win_q : win_q + 1'b1;
      run_inc  = tok1_q ? ((run_q == RUN_MAX) ? run_q : run_q + 1'b1) : '0;

      case (state_q)
         ST_SEARCH: begin
            win_d = win_inc;
            run_d = run_inc;
            if (run_inc == RUN_MAX) begin
               // Lock takes priority over a window expiry in the same cycle.
               state_d = ST_LOCKED;
               win_d   = '0;
               run_d   = '0;
               perr_d  = 1'b0;
            end else if (win_inc == WIN_MAX) begin
               state_d = ST_SLIP;
               win_d   = '0;
               run_d   = '0;
               if (slip_q == SLIP_LAST) begin
                  slip_d = '0;
                  perr_d = 1'b1;
               end else begin
                  slip_d = slip_q + 1'b1;
               end
            end
         end

         ST_SLIP: begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            win_d    = '0;
            run_d    = '0;
         end

         ST_SETTLE: begin
            win_d = '0;
            run_d = '0;
            if (settle_q == SET_LAST) begin
               state_d  = ST_SEARCH;
               settle_d = '0;
            end else begin
               settle_d = settle_q + 1'b1;
            end
         end

         ST_LOCKED: begin
            run_d = '0;
            win_d = tok1_q ? '0 : win_inc;
            if (!tok1_q && (win_inc == WIN_MAX)) begin
               // Lost lock: restart the search from the current slip phase.
               state_d = ST_SEARCH;
               win_d   = '0;
            end
         end

         default: begin
            state_d = ST_SEARCH;
            win_d   = '0;
            run_d   = '0;
         end
      endcase
   end

   // FSM and counter registers.
   always_ff @(posedge pclk) begin
      if (rstin) begin
         state_q  <= ST_SEARCH;
         win_q    <= '0;
         run_q    <= '0;
         slip_q   <= '0;
         settle_q <= '0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         run_q    <= run_d;
         slip_q   <= slip_d;
         settle_q <= settle_d;
         perr_q   <= perr_d;
      end
   end

   assign aligned   = (state_q == ST_LOCKED);
   assign bitslip   = (state_q == ST_SLIP);
   assign psalgnerr = perr_q;
   assign dout      = dout_q;
   assign vde       = vde_q;
   assign c0        = c0_q;
   assign c1        = c1_q;

endmodule

// File: tb/tb_tmds_chan_decode.sv
// Testbench for tmds_chan_decode: lock/slip/loss sequences plus a table of
// decode vectors checked through a scoreboard queue.
`timescale 1ns/1ps
module tb_tmds_chan_decode;

   localparam int SEARCH_WIN  = 4096;
   localparam int CTRL_RUN    = 64;
   localparam int SLIP_SETTLE = 3;
   localparam int SLIP_GAP    = SEARCH_WIN + 1 + SLIP_SETTLE;

   localparam logic [9:0] TOK00 = 10'h354;  // 1101010100
   localparam logic [9:0] TOK01 = 10'h0AB;  // 0010101011
   localparam logic [9:0] TOK10 = 10'h154;  // 0101010100
   localparam logic [9:0] TOK11 = 10'h2AB;  // 1010101011

   logic       pclk = 1'b0;
   logic       rstin;
   logic [9:0] sdata;
   logic       bitslip, aligned, psalgnerr, c0, c1, vde;
   logic [7:0] dout;

   tmds_chan_decode #(
      .SEARCH_WIN (SEARCH_WIN),
      .CTRL_RUN   (CTRL_RUN),
      .SLIP_SETTLE(SLIP_SETTLE)
   ) dut (
      .pclk     (pclk),
      .rstin    (rstin),
      .sdata    (sdata),
      .bitslip  (bitslip),
      .aligned  (aligned),
      .psalgnerr(psalgnerr),
      .dout     (dout),
      .c0       (c0),
      .c1       (c1),
      .vde      (vde)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      logic [9:0] word;
      logic [7:0] dout;
      logic       vde;
      logic       c1;
      logic       c0;
   } vec_t;

   typedef struct {
      int         due;
      int         idx;
      logic [7:0] dout;
      logic       vde;
      logic       c1;
      logic       c0;
   } exp_t;

   exp_t sb[$];
   int   slip_cyc[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   nslip    = 0;
   bit   rot_en   = 1'b0;
   int   phase    = 0;
   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
      logic [9:0] r;
      r = w;
      for (int i = 0; i < n; i++) r = {r[8:0], r[9]};
      return r;
   endfunction

   // One clock: sample 1ns after the edge, model the deserializer slip,
   // retire any scoreboard entries that fall due on this cycle.
   task automatic step();
      @(posedge pclk);
      #1;
      cyc++;
      if (bitslip === 1'b1) begin
         nslip++;
         slip_cyc.push_back(cyc);
         if (rot_en) begin
            phase = (phase + 1) % 10;
            sdata = rotl(TOK00, phase);
         end
      end
      while (sb.size() > 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         check($sformatf("vec%0d", e.idx), {dout, vde, c1, c0}, {e.dout, e.vde, e.c1, e.c0});
      end
   endtask

   task automatic reset_dut();
      rstin = 1'b1;
      step();
      check("reset_outs", {bitslip, aligned, psalgnerr, dout, c1, c0, vde}, 0);
      repeat (2) step();
      rstin = 1'b0;
      cyc   = 0;
      nslip = 0;
      slip_cyc.delete();
   endtask

   // Watchdog: the whole run is well under 1 ms of simulated time.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rstin = 1'b1;
      sdata = TOK00;

      // Hand-decoded vectors: {word, dout, vde, c1, c0}; c holds across video.
      vecs[0]  = '{10'h100, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{10'h3FF, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{10'h200, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{10'h0FF, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{10'h155, 8'hFF, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{10'h0AA, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{10'h2F0, 8'hEF, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{10'h13C, 8'h44, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{TOK01,   8'h00, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{10'h100, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{10'h2F0, 8'hEF, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{TOK11,   8'h00, 1'b0, 1'b1, 1'b1};
      vecs[12] = '{TOK10,   8'h00, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{10'h13C, 8'h44, 1'b1, 1'b1, 1'b0};
      vecs[14] = '{TOK00,   8'h00, 1'b0, 1'b0, 1'b0};

      // ---- Lock on an aligned token stream ----
      reset_dut();
      repeat (CTRL_RUN) step();
      check("pre_lock", aligned, 0);
      repeat (2) step();
      check("lock", aligned, 1);
      check("lock_ctrl", {c1, c0, vde, dout}, 0);
      check("lock_no_slip", nslip, 0);

      // ---- Decode table through the scoreboard (2-edge latency) ----
      for (int i = 0; i < 15; i++) begin
         sdata = vecs[i].word;
         sb.push_back('{cyc + 2, i, vecs[i].dout, vecs[i].vde, vecs[i].c1, vecs[i].c0});
         step();
      end
      sdata = TOK00;
      repeat (3) step();
      check("sb_drained", sb.size(), 0);

      // ---- Loss of lock: the first edge that samples 10'h100 is e=1 ----
      repeat (4) step();
      sdata = 10'h100;
      for (int e = 1; e <= SEARCH_WIN + 2; e++) begin
         step();
         if (e == SEARCH_WIN)     check("loss_hold", aligned, 1);
         if (e == SEARCH_WIN + 1) check("loss_fall", aligned, 0);
      end
      check("loss_gate", {vde, dout, c1, c0}, 0);

      // ---- Token stream rotated by 3 bits: 7 slips to reach phase 0 ----
      phase = 3;
      sdata = rotl(TOK00, phase);
      reset_dut();
      rot_en = 1'b1;
      for (int i = 0; i < 40000 && aligned !== 1'b1; i++) step();
      rot_en = 1'b0;
      check("rot_locked", aligned, 1);
      check("rot_pulses", nslip, 7);
      check("rot_perr", psalgnerr, 0);
      check("rot_first_slip", (slip_cyc.size() > 0) ? slip_cyc[0] : -1, SEARCH_WIN);
      for (int k = 1; k < slip_cyc.size(); k++)
         check($sformatf("rot_gap%0d", k), slip_cyc[k] - slip_cyc[k-1], SLIP_GAP);

      // ---- Never-aligning stream: psalgnerr on the 10th pulse ----
      sdata = 10'h100;
      reset_dut();
      for (int i = 0; i < 45000 && nslip < 10; i++) begin
         step();
         if (nslip == 9 && bitslip === 1'b1) check("perr_9th", psalgnerr, 0);
      end
      check("perr_pulses", nslip, 10);
      check("perr_10th", {bitslip, psalgnerr}, 2'b11);
      check("perr_10th_cyc", (slip_cyc.size() >= 10) ? slip_cyc[9] : -1,
            SEARCH_WIN + 9 * SLIP_GAP);

      // Two cycles into SETTLE, then reset.
      repeat (2) step();
      check("settle_quiet", bitslip, 0);
      rstin = 1'b1;
      step();
      check("rst_settle", {psalgnerr, bitslip, aligned}, 0);
      rstin = 1'b0;
      cyc   = 0;
      nslip = 0;
      slip_cyc.delete();
      for (int i = 1; i <= SEARCH_WIN; i++) begin
         step();
         if (i == SEARCH_WIN - 1) check("post_rst_quiet", nslip, 0);
      end
      check("post_rst_slip", {bitslip, psalgnerr}, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
